// File: rtl/cos_acc_pkg.sv
// Shared types for the cos(x) accelerator job issuer: FSM states, default widths,
// and the result FIFO entry layout.
package cos_acc_pkg;

    localparam int unsigned X_W_DEF = 16;
    localparam int unsigned Y_W_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone,
        StCapture
    } issuer_state_t;

    typedef struct packed {
        logic                err;
        logic [Y_W_DEF-1:0]  y;
    } result_t;

endpackage

// File: rtl/cos_result_fifo.sv
// Synchronous result FIFO with a registered head; head changes only on pop or
// on a push into an empty FIFO.
module cos_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 17
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_C  = (PW+1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_next;
    logic [PW:0]   count_q;
    logic [W-1:0]  head_q;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != FULL_C) || do_pop);
        rd_next = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_next;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
            // Next head comes from the incoming word only when it becomes the sole entry.
            if (do_push && ((count_q == '0) || (do_pop && (count_q == ONE_C)))) begin
                head_q <= push_data_i;
            end else if (do_pop && (count_q > ONE_C)) begin
                head_q <= mem_q[rd_next];
            end
        end
    end

    assign head_o  = head_q;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/cos_job_issuer.sv
// Host-side initiator for the cos(x) accelerator: issues one job at a time over the
// start/ready handshake, detects completion or timeout, and queues results.
module cos_job_issuer
    import cos_acc_pkg::*;
#(
    parameter int unsigned X_W       = X_W_DEF,
    parameter int unsigned Y_W       = Y_W_DEF,
    parameter int unsigned START_LEN = 1,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned DEPTH     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [X_W-1:0] in_x,
    output logic           in_ready,
    output logic           acc_start,
    output logic [X_W-1:0] acc_x,
    input  logic           acc_ready,
    input  logic [Y_W-1:0] acc_y,
    output logic           out_valid,
    output logic [Y_W-1:0] out_y,
    output logic           out_err,
    input  logic           out_ready,
    output logic           busy,
    output logic [7:0]     timeouts
);

    localparam int unsigned SW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [SW-1:0] START_LAST = SW'(START_LEN - 1);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

    issuer_state_t  state_q;
    logic [SW-1:0]  start_cnt_q;
    logic [WW-1:0]  wdog_q;
    logic [WW-1:0]  wdog_inc;
    logic           acc_start_q;
    logic [X_W-1:0] acc_x_q;
    logic [Y_W-1:0] y_cap_q;
    logic [7:0]     timeouts_q;
    logic           init_q;

    logic           accept;
    logic           abort;
    logic           push;
    logic [Y_W:0]   push_data;
    logic [Y_W:0]   head;
    logic [CW-1:0]  fifo_count;

    always_comb begin
        // The slot checked here is the one the outstanding job will later fill.
        in_ready  = init_q && (state_q == StIdle) && acc_ready && (fifo_count < DEPTH_C);
        accept    = in_valid && in_ready;
        wdog_inc  = (wdog_q == WDOG_LAST) ? wdog_q : wdog_q + 1'b1;
        abort     = 1'b0;
        if (wdog_q == WDOG_LAST) begin
            if (state_q == StWaitBusy) begin
                abort = acc_ready;
            end else if (state_q == StWaitDone) begin
                abort = !acc_ready;
            end
        end
        push      = abort || (state_q == StCapture);
        push_data = abort ? {1'b1, {Y_W{1'b0}}} : {1'b0, y_cap_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            start_cnt_q <= '0;
            wdog_q      <= '0;
            acc_start_q <= 1'b0;
            acc_x_q     <= '0;
            y_cap_q     <= '0;
            timeouts_q  <= '0;
            init_q      <= 1'b0;
        end else begin
            init_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        acc_x_q     <= in_x;
                        acc_start_q <= 1'b1;
                        start_cnt_q <= '0;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (start_cnt_q == START_LAST) begin
                        acc_start_q <= 1'b0;
                        wdog_q      <= '0;
                        state_q     <= StWaitBusy;
                    end else begin
                        start_cnt_q <= start_cnt_q + 1'b1;
                    end
                end
                StWaitBusy: begin
                    // The watchdog keeps running into WAIT_DONE: one budget per job.
                    if (!acc_ready) begin
                        wdog_q  <= wdog_inc;
                        state_q <= StWaitDone;
                    end else if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        wdog_q <= wdog_inc;
                    end
                end
                StWaitDone: begin
                    if (acc_ready) begin
                        y_cap_q <= acc_y;
                        state_q <= StCapture;
                    end else if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        wdog_q <= wdog_inc;
                    end
                end
                StCapture: begin
                    state_q <= StIdle;
                end
                default: begin
                    acc_start_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
            if (abort && (timeouts_q != 8'hFF)) begin
                timeouts_q <= timeouts_q + 1'b1;
            end
        end
    end

    cos_result_fifo #(
        .DEPTH (DEPTH),
        .W     (Y_W + 1)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (out_ready),
        .head_o      (head),
        .valid_o     (out_valid),
        .count_o     (fifo_count)
    );

    assign acc_start = acc_start_q;
    assign acc_x     = acc_x_q;
    assign out_err   = head[Y_W];
    assign out_y     = head[Y_W-1:0];
    assign busy      = (state_q != StIdle);
    assign timeouts  = timeouts_q;

endmodule
